// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - edge-latched, maskable, fixed-priority interrupt controller with NMI path
module int_ctrl #(
    parameter int                   NUM_SRC  = 8,
    parameter int                   ID_W     = 3,
    parameter logic [NUM_SRC-1:0]   MASK_RST = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  src,
    input  logic                nmi_src,
    input  logic                mask_we,
    input  logic [NUM_SRC-1:0]  mask_wdata,
    output logic [NUM_SRC-1:0]  mask_q,
    output logic                irq,
    output logic                nmi,
    input  logic                irq_ack,
    input  logic                nmi_ack,
    input  logic                eoi,
    output logic [ID_W-1:0]     irq_id,
    output logic [NUM_SRC-1:0]  pending,
    output logic                in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   src_q, src_d;
    logic                 nmi_q, nmi_d;
    logic                 edge_arm_q, edge_arm_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   mask_d;
    logic                 nmi_pend_q, nmi_pend_d;
    logic                 irq_q, irq_d;
    logic                 in_service_q, in_service_d;
    logic [ID_W-1:0]      irq_id_q, irq_id_d;

    logic [NUM_SRC-1:0]   src_edge;
    logic                 nmi_edge;
    logic                 ack_take;
    logic [NUM_SRC-1:0]   clr_vec;
    logic [NUM_SRC-1:0]   req_vec;
    logic [ID_W-1:0]      arb_id;

    // Edge detection, pending/NMI latches and mask; edge_arm_q swallows the first
    // post-reset cycle so lines held high through reset never look like new edges.
    always_comb begin
        src_d      = src;
        nmi_d      = nmi_src;
        edge_arm_d = 1'b1;
        src_edge   = edge_arm_q ? (src & ~src_q) : '0;
        nmi_edge   = edge_arm_q & nmi_src & ~nmi_q;
        ack_take   = (state_q == REQ) & irq_ack;
        clr_vec    = '0;
        if (ack_take) begin
            clr_vec[irq_id_q] = 1'b1;
        end
        pending_d  = (pending_q & ~clr_vec) | src_edge;
        mask_d     = mask_we ? mask_wdata : mask_q;
        nmi_pend_d = (nmi_pend_q & ~nmi_ack) | nmi_edge;
        req_vec    = pending_q & mask_q;
        arb_id     = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                arb_id = ID_W'(i);
            end
        end
    end

    // Next-state logic: one request in flight until end-of-interrupt, no nesting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_vec) state_d = REQ;
            REQ:     if (irq_ack)  state_d = SERVICE;
            SERVICE: if (eoi)      state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Output logic: outputs are registered from the next state; id latched only on arbitration.
    always_comb begin
        irq_d        = (state_d == REQ);
        in_service_d = (state_d == SERVICE);
        irq_id_d     = irq_id_q;
        if (state_q == IDLE && |req_vec) begin
            irq_id_d = arb_id;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q        <= '0;
            nmi_q        <= 1'b0;
            edge_arm_q   <= 1'b0;
            pending_q    <= '0;
            mask_q       <= MASK_RST;
            nmi_pend_q   <= 1'b0;
            irq_q        <= 1'b0;
            in_service_q <= 1'b0;
            irq_id_q     <= '0;
        end else begin
            src_q        <= src_d;
            nmi_q        <= nmi_d;
            edge_arm_q   <= edge_arm_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            nmi_pend_q   <= nmi_pend_d;
            irq_q        <= irq_d;
            in_service_q <= in_service_d;
            irq_id_q     <= irq_id_d;
        end
    end

    assign irq        = irq_q;
    assign nmi        = nmi_pend_q;
    assign in_service = in_service_q;
    assign irq_id     = irq_id_q;
    assign pending    = pending_q;

endmodule
